memory_8k_x18: RTL and testbench
================================

// Module: memory_8k_x18
// PURPOSE
//   Single-port synchronous RAM, 8192 words x 18 bits, one shared address bus.
//   Synchronous write. Registered read with one cycle of latency.
//   Serves as a general data store for the datapath.
//   Provides separate read and write enables.
//   Has an asynchronous output clear on reset; the stored array is never cleared.
// PARAMETERS
//   DATA_W   18            word width in bits
//   ADDR_W   13            address width in bits
//   DEPTH    2**ADDR_W     number of words (8192)
// PORTS
//   clk       in   1       system clock; all state changes on rising edge
//   rst       in   1       asynchronous, active-high reset
//   re_en     in   1       read enable; high = capture mem[in_adrs] into output register
//   wr_en     in   1       write enable; high = store inD at mem[in_adrs]
//   in_adrs   in   13      word address, shared by read and write
//   inD       in   18      write data
//   ouD_add   out  18      registered read data
// BEHAVIOUR
//   - Single clock domain (clk). Reset is asynchronous and active-high (rst).
//   - rst asserted:
//     - ouD_add goes to 18'd0 immediately, with no clock required.
//     - ouD_add stays 0 while rst is high.
//     - Writes are blocked while rst is high.
//     - Array contents are NOT altered by reset. Contents are undefined after power-up.
//   - Write, on a clk rise with rst=0 and wr_en=1:
//     - mem[in_adrs] <= inD.
//     - Visible to a read on the next edge.
//   - Read, on a clk rise with rst=0 and re_en=1:
//     - ouD_add <= mem[in_adrs].
//     - Data is valid after that edge, i.e. 1-cycle latency.
//   - re_en=0: ouD_add holds its last value. There is no bubble or zeroing.
//   - re_en=1 and wr_en=1 on the same edge, same address:
//     - Write-first: ouD_add <= inD.
//     - The array is updated as well.
//   - Both enables low: no state change.
//   - Address range:
//     - All 13-bit addresses 0..8191 are valid.
//     - No out-of-range case exists and there is no wrap logic.
//   - Enables sampled only at clk edges. No handshake, always ready, no stall.
//   - Release of rst:
//     - The first edge after deassertion may perform a read or write normally.
//     - Assertion in mid-operation aborts that edge's write/read.
//   - Array inferable as block RAM. The output register is the only reset flop.
// TESTING
//   1. Reset: rst=1 with ouD_add previously nonzero -> ouD_add=0 before the next clk edge.
//   2. Sequential write/read-back:
//      - Write 10,11,...,59 to addresses 0..49 (wr_en=1, re_en=0).
//      - Then read 0..49 with re_en=1 -> ouD_add = 10+addr, one cycle after each address.
//   3. Hold: after reading addr 3 (=13), drop re_en and change in_adrs -> ouD_add stays 13.
//   4. Collision: re_en=wr_en=1, addr 100, inD=18'h3FFFF -> ouD_add=18'h3FFFF next cycle.
//      A later read of 100 also returns 18'h3FFFF.
//   5. Reset preserves data and blocks writes:
//      - Write 5 to addr 8191, pulse rst, then read 8191 -> 5 (ouD_add was 0 during rst).
//      - wr_en=1 with rst=1 leaves the word unchanged.
//   6. Extremes: write 0 at addr 0 and 18'h3FFFF at addr 8191 -> both read back exactly.
//      Neither address aliases the other.

Source files
------------

// File: rtl/memory_8k_x18.sv
// 8192 x 18 single-port synchronous RAM with a registered, write-first read port.
// Only the output register is reset; the array keeps its contents across reset.
module memory_8k_x18 #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] in_adrs,
  input  logic [DATA_W-1:0] inD,
  output logic [DATA_W-1:0] ouD_add
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write lives under the reset branch so reset also blocks writes;
  // the array itself is never assigned in the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ouD_add <= '0;
    end else begin
      if (wr_en) mem[in_adrs] <= inD;
      if (re_en) ouD_add <= wr_en ? inD : mem[in_adrs];
    end
  end

endmodule

// File: tb/tb_memory_8k_x18.sv
// Directed self-checking bench for memory_8k_x18: reset, read-back, hold,
// write-first collision, reset persistence and address extremes.
module tb_memory_8k_x18;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_en;
  logic        wr_en;
  logic [12:0] in_adrs;
  logic [17:0] inD;
  logic [17:0] ouD_add;

  int checks = 0;
  int errors = 0;

  memory_8k_x18 dut (
    .clk     (clk),
    .rst     (rst),
    .re_en   (re_en),
    .wr_en   (wr_en),
    .in_adrs (in_adrs),
    .inD     (inD),
    .ouD_add (ouD_add)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic re, input logic we, input logic [12:0] a, input logic [17:0] d);
    @(negedge clk);
    re_en = re; wr_en = we; in_adrs = a; inD = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; re_en = 1'b0; wr_en = 1'b0; in_adrs = '0; inD = '0;
    #1;
    check("reset_init", ouD_add, 18'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 50; a++) cycle(1'b0, 1'b1, 13'(a), 18'(10 + a));
    for (int a = 0; a < 50; a++) begin
      cycle(1'b1, 1'b0, 13'(a), 18'h0);
      check($sformatf("readback_%0d", a), ouD_add, 18'(10 + a));
    end

    cycle(1'b1, 1'b0, 13'd3, 18'h0);
    check("hold_pre", ouD_add, 18'd13);
    cycle(1'b0, 1'b0, 13'd7, 18'h0);
    cycle(1'b0, 1'b0, 13'd40, 18'h0);
    check("hold", ouD_add, 18'd13);

    cycle(1'b1, 1'b1, 13'd100, 18'h3FFFF);
    check("collision_out", ouD_add, 18'h3FFFF);
    cycle(1'b1, 1'b0, 13'd0, 18'h0);
    check("collision_mid", ouD_add, 18'd10);
    cycle(1'b1, 1'b0, 13'd100, 18'h0);
    check("collision_array", ouD_add, 18'h3FFFF);

    cycle(1'b0, 1'b1, 13'd8191, 18'd5);
    cycle(1'b1, 1'b0, 13'd0, 18'h0);
    check("pre_reset_nonzero", ouD_add, 18'd10);
    @(negedge clk);
    rst = 1'b1; re_en = 1'b1; wr_en = 1'b1; in_adrs = 13'd8191; inD = 18'd777;
    #1;
    check("async_clear", ouD_add, 18'd0);
    @(posedge clk);
    #1;
    check("reset_hold", ouD_add, 18'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; re_en = 1'b1; in_adrs = 13'd8191;
    @(posedge clk);
    #1;
    check("reset_preserve", ouD_add, 18'd5);

    cycle(1'b0, 1'b1, 13'd0, 18'd0);
    cycle(1'b0, 1'b1, 13'd8191, 18'h3FFFF);
    cycle(1'b1, 1'b0, 13'd0, 18'h0);
    check("extreme_lo", ouD_add, 18'd0);
    cycle(1'b1, 1'b0, 13'd8191, 18'h0);
    check("extreme_hi", ouD_add, 18'h3FFFF);
    cycle(1'b1, 1'b0, 13'd0, 18'h0);
    check("extreme_lo_again", ouD_add, 18'd0);
    cycle(1'b1, 1'b0, 13'd1, 18'h0);
    check("neighbor_1", ouD_add, 18'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
